// File: rtl/display_pkg.sv
// Shared display timing constants, sprite table entry type and scan FSM states
// for the sprite line scheduler.
package display_pkg;

    localparam int unsigned NUM_SPR      = 16;
    localparam int unsigned MAX_PER_LINE = 8;
    localparam int unsigned SPR_W        = 48;
    localparam int unsigned SPR_H        = 64;
    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned V_TOTAL      = 525;

    localparam int unsigned IDX_W  = $clog2(NUM_SPR);
    localparam int unsigned SLOT_W = $clog2(MAX_PER_LINE);

    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
    } spr_entry_t;

    typedef enum logic [1:0] {StIdle, StScan, StDone} scan_state_e;

    // start <= pos < start+len in 11 bits, so spans running past 1023 clip instead of wrapping
    function automatic logic in_span(logic [9:0] pos, logic [9:0] start, int unsigned len);
        logic [10:0] p;
        logic [10:0] s;
        p = {1'b0, pos};
        s = {1'b0, start};
        return (s <= p) && (p < s + 11'(len));
    endfunction

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Sprite table write port: valid/ready handshake carrying one table entry.
interface sprite_line_scheduler_if;
    import display_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_en;
    logic [9:0]       wr_x;
    logic [9:0]       wr_y;

    modport master (output wr_valid, wr_idx, wr_en, wr_x, wr_y, input wr_ready);
    modport slave  (input wr_valid, wr_idx, wr_en, wr_x, wr_y, output wr_ready);

endinterface

// File: rtl/sprite_priority_sel.sv
// Combinational pick of the lowest-numbered line slot covering pixel x,
// returning the slot index and sprite-local x offset.
module sprite_priority_sel
    import display_pkg::*;
(
    input  spr_entry_t        slot_i [MAX_PER_LINE],
    input  logic [9:0]        x_i,
    output logic              hit_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic [5:0]        u_o
);

    logic [9:0] dx;

    always_comb begin
        hit_o  = 1'b0;
        slot_o = '0;
        u_o    = '0;
        dx     = '0;
        // Walk downwards so the lowest matching slot is the last one written
        for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
            if (slot_i[i].en && in_span(x_i, slot_i[i].x, SPR_W)) begin
                hit_o  = 1'b1;
                slot_o = SLOT_W'(i);
                dx     = x_i - slot_i[i].x;
                u_o    = dx[5:0];
            end
        end
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: builds the next line's sprite list during
// horizontal blanking and reports the winning sprite per pixel with one cycle latency.
module sprite_line_scheduler
    import display_pkg::*;
(
    input  logic                     i_clk_25M,
    input  logic                     i_rst_n,
    input  logic [9:0]               i_x_cnt,
    input  logic [9:0]               i_y_cnt,
    sprite_line_scheduler_if.slave   wr,
    output logic                     o_hit,
    output logic [IDX_W-1:0]         o_spr_id,
    output logic [5:0]               o_u,
    output logic [5:0]               o_v,
    output logic                     o_overflow
);

    spr_entry_t       shadow_q   [NUM_SPR];
    spr_entry_t       shadow_d   [NUM_SPR];
    spr_entry_t       act_q      [NUM_SPR];
    spr_entry_t       act_d      [NUM_SPR];
    spr_entry_t       pend_ent_q [MAX_PER_LINE];
    spr_entry_t       pend_ent_d [MAX_PER_LINE];
    logic [IDX_W-1:0] pend_id_q  [MAX_PER_LINE];
    logic [IDX_W-1:0] pend_id_d  [MAX_PER_LINE];
    spr_entry_t       list_ent_q [MAX_PER_LINE];
    spr_entry_t       list_ent_d [MAX_PER_LINE];
    logic [IDX_W-1:0] list_id_q  [MAX_PER_LINE];
    logic [IDX_W-1:0] list_id_d  [MAX_PER_LINE];
    logic [SLOT_W:0]  pend_cnt_q, pend_cnt_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    scan_state_e      state_q, state_d;
    logic             ovf_q, ovf_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic [5:0]       u_q, u_d;
    logic [5:0]       v_q, v_d;

    logic              line_end, commit, wr_ready, accept, in_active;
    logic [9:0]        ny, dy;
    spr_entry_t        cand;
    logic              sel_hit;
    logic [SLOT_W-1:0] sel_slot;
    logic [5:0]        sel_u;

    assign line_end = (i_x_cnt == 10'(H_TOTAL - 1));
    assign commit   = line_end && (i_y_cnt == 10'(V_ACTIVE - 1));
    assign wr_ready = !commit;
    assign wr.wr_ready = wr_ready;
    assign ny       = (i_y_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : i_y_cnt + 10'd1;
    assign cand     = act_q[scan_idx_q];
    assign accept   = cand.en && in_span(ny, cand.y, SPR_H);

    always_comb begin
        shadow_d = shadow_q;
        act_d    = act_q;
        if (wr.wr_valid && wr_ready) begin
            shadow_d[wr.wr_idx] = {wr.wr_en, wr.wr_x, wr.wr_y};
        end
        if (commit) begin
            act_d = shadow_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        pend_ent_d = pend_ent_q;
        pend_id_d  = pend_id_q;
        pend_cnt_d = pend_cnt_q;
        list_ent_d = list_ent_q;
        list_id_d  = list_id_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (i_x_cnt == 10'(H_ACTIVE)) begin
                    state_d    = StScan;
                    scan_idx_d = '0;
                end
            end
            StScan: begin
                if (accept) begin
                    if (pend_cnt_q == (SLOT_W + 1)'(MAX_PER_LINE)) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_ent_d[pend_cnt_q[SLOT_W-1:0]] = cand;
                        pend_id_d[pend_cnt_q[SLOT_W-1:0]]  = scan_idx_q;
                        pend_cnt_d = pend_cnt_q + 1'b1;
                    end
                end
                scan_idx_d = scan_idx_q + 1'b1;
                if (scan_idx_q == IDX_W'(NUM_SPR - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (line_end) begin
                    state_d    = StIdle;
                    list_ent_d = pend_ent_q;
                    list_id_d  = pend_id_q;
                    pend_cnt_d = '0;
                    for (int i = 0; i < MAX_PER_LINE; i++) begin
                        pend_ent_d[i] = '0;
                        pend_id_d[i]  = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (commit) begin
            ovf_d = 1'b0;
        end
    end

    sprite_priority_sel u_sel (
        .slot_i (list_ent_q),
        .x_i    (i_x_cnt),
        .hit_o  (sel_hit),
        .slot_o (sel_slot),
        .u_o    (sel_u)
    );

    always_comb begin
        in_active = (i_x_cnt < 10'(H_ACTIVE)) && (i_y_cnt < 10'(V_ACTIVE));
        hit_d     = in_active && sel_hit;
        dy        = i_y_cnt - list_ent_q[sel_slot].y;
        id_d      = hit_d ? list_id_q[sel_slot] : '0;
        u_d       = hit_d ? sel_u : '0;
        v_d       = hit_d ? dy[5:0] : '0;
    end

    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                shadow_q[i] <= '0;
                act_q[i]    <= '0;
            end
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                pend_ent_q[i] <= '0;
                pend_id_q[i]  <= '0;
                list_ent_q[i] <= '0;
                list_id_q[i]  <= '0;
            end
            pend_cnt_q <= '0;
            scan_idx_q <= '0;
            state_q    <= StIdle;
            ovf_q      <= 1'b0;
            hit_q      <= 1'b0;
            id_q       <= '0;
            u_q        <= '0;
            v_q        <= '0;
        end else begin
            shadow_q   <= shadow_d;
            act_q      <= act_d;
            pend_ent_q <= pend_ent_d;
            pend_id_q  <= pend_id_d;
            list_ent_q <= list_ent_d;
            list_id_q  <= list_id_d;
            pend_cnt_q <= pend_cnt_d;
            scan_idx_q <= scan_idx_d;
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            hit_q      <= hit_d;
            id_q       <= id_d;
            u_q        <= u_d;
            v_q        <= v_d;
        end
    end

    assign o_hit      = hit_q;
    assign o_spr_id   = id_q;
    assign o_u        = u_q;
    assign o_v        = v_q;
    assign o_overflow = ovf_q;

endmodule
